logo_scroll_painter: RTL and testbench
======================================

Name: logo_scroll_painter

Overview:
- Sequential successor to the single-letter VGA logo painters.
- Paints a string of NUM_GLYPHS bitmap letters, each scaled by 2^SCALE_LOG2, at a horizontal offset that bounces back and forth once per frame.
- Sits between the VGA timing generator (pixel x/y, frame_start) and the colour mux.
- Outputs a pipelined hit flag and the index of the glyph hit.

Parameters:
- NUM_GLYPHS, 4: number of letter slots in the string.
- SCALE_LOG2, 2: each glyph pixel is drawn as a 2^SCALE_LOG2 square. Glyph cell is 8x8 source pixels.
- GAP, 4: screen pixels between adjacent glyph cells.
- X_BASE, 500: left edge of slot 0 when the offset is 0.
- Y_BASE, 550: top edge of all glyphs.
- DELT_MAX, 100: maximum horizontal offset.
- STEP, 2: offset change per frame.
- PAUSE_FRAMES, 30: frames to hold at each end of travel.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- enable  in  1  painting and animation enable
- frame_start  in  1  one-cycle pulse at start of vertical blank
- x  in  11  current pixel column
- y  in  11  current pixel row
- text_codes  in  4*NUM_GLYPHS  glyph code per slot, slot 0 in the LSBs
- hit  out  1  pixel belongs to a lit glyph pixel (2-cycle latency)
- hit_index  out  clog2(NUM_GLYPHS)  slot producing the hit; 0 when hit=0
- delt  out  11  current horizontal offset

Behaviour:
- Reset: hit=0, hit_index=0, delt=0, state=MOVE_RIGHT, pause counter=0. All pipeline registers are cleared. Reset mid-frame or mid-pause takes effect on the next edge.
- Pipeline stage 1 (registered):
  - Computes dx = x - X_BASE - delt and dy = y - Y_BASE in 13-bit signed arithmetic.
  - Slot pitch P = 8<<SCALE_LOG2 + GAP.
  - Slot i is selected when dx lies in [i*P, i*P + (8<<SCALE_LOG2)) and dy lies in [0, 8<<SCALE_LOG2).
  - Column = (dx - i*P) >> SCALE_LOG2; row = dy >> SCALE_LOG2.
  - A valid bit is registered. Negative or out-of-range dx/dy gives valid=0.
- Pipeline stage 2 (registered):
  - Looks up the glyph row byte for the selected slot's code.
  - hit = valid & bit[7-col] & enable_d2, where enable_d2 is enable delayed 2 cycles.
  - hit_index is the registered slot number.
- Latency: the x/y presented at cycle t produce hit at t+2, exactly.
- Animation FSM (advances only on frame_start & enable):
  - MOVE_RIGHT: delt += STEP, saturating at DELT_MAX. On reaching DELT_MAX, go to PAUSE_R with counter=0.
  - PAUSE_R: counter increments. When it reaches PAUSE_FRAMES-1, go to MOVE_LEFT.
  - MOVE_LEFT: delt -= STEP, saturating at 0. On reaching 0, go to PAUSE_L.
  - PAUSE_L: same as PAUSE_R, then go to MOVE_RIGHT.
  - PAUSE_FRAMES=0: the pause states are skipped.
- Width rule: delt never exceeds DELT_MAX and never goes negative (no wrap). Glyphs extending past x=2047 are clipped, not wrapped.
- enable=0:
  - delt and state are frozen.
  - frame_start is ignored.
  - hit is forced 0 (with matching 2-cycle delay).
- Code 0 is blank, so it never hits. Codes 1..15 are defined in the package ROM table.
- Changes to text_codes take effect at the pixel sampled 2 cycles before hit is observed. No latching is required.

Optional Feature:
- LOGO_BLINK_EN:
  - Defined: adds an 6-bit frame counter, incremented on every frame_start while enable=1 and cleared by rst. hit is additionally gated by counter[5], so the logo is visible 32 frames and dark 32 frames. delt animation is unaffected.
  - Undefined: no counter is present and hit is never gated.

Decomposition:
- Package logo_pkg holds:
  - glyph code constants: BLANK=0, A=1, C=2, E=3, G=4, H=5, I=6, L=7, M=8, N=9, O=10, P=11, R=12, S=13, T=14, U=15;
  - the 16x8 row-byte ROM table;
  - the FSM state enum (MOVE_RIGHT, PAUSE_R, MOVE_LEFT, PAUSE_L).
- One sub-module, logo_glyph_rom:
  - input: code (4), row (3);
  - output: bits (8);
  - purely combinational.

Test Plan:
- Reset then frame_start pulses with enable=1, STEP=2, DELT_MAX=100 -> delt=2,4,...,100 after 50 frames; it stays 100 for 30 frames, then counts 98, 96, ... down.
- text_codes={0,0,0,A}, delt=0; scan y=550, x=500..531 -> hit at t+2 matches the top row byte of A, each bit repeated 4 pixels; hit_index=0.
- Slot boundary: x=532..535 (the gap) -> hit=0. x=536 with slot 1 = M -> hit follows the M row-0 MSB; hit_index=1.
- enable deasserted for 10 frame_start pulses at delt=40 -> delt stays 40, hit=0 throughout. Re-enable -> next frame delt=42.
- rst asserted in PAUSE_L at counter=12 -> next cycle delt=0, state=MOVE_RIGHT; the following frame_start gives delt=2.
- LOGO_BLINK_EN defined -> hit is suppressed for frames 0-31 after reset and present for frames 32-63, with delt unaffected.

Source files
------------

// File: rtl/logo_pkg.sv
// Shared definitions for the scrolling logo painter: glyph codes,
// the 16x8 glyph row-byte ROM and the animation state type.
package logo_pkg;

   // Glyph codes; code 0 is blank and never lights a pixel.
   localparam logic [3:0] BLANK = 4'd0;
   localparam logic [3:0] A     = 4'd1;
   localparam logic [3:0] C     = 4'd2;
   localparam logic [3:0] E     = 4'd3;
   localparam logic [3:0] G     = 4'd4;
   localparam logic [3:0] H     = 4'd5;
   localparam logic [3:0] I     = 4'd6;
   localparam logic [3:0] L     = 4'd7;
   localparam logic [3:0] M     = 4'd8;
   localparam logic [3:0] N     = 4'd9;
   localparam logic [3:0] O     = 4'd10;
   localparam logic [3:0] P     = 4'd11;
   localparam logic [3:0] R     = 4'd12;
   localparam logic [3:0] S     = 4'd13;
   localparam logic [3:0] T     = 4'd14;
   localparam logic [3:0] U     = 4'd15;

   // One 64-bit word per code: row 0 in bits [63:56], row 7 in [7:0].
   // Within a row byte the MSB is the leftmost pixel.
   localparam logic [63:0] GLYPH_ROM [16] = '{
      64'h0000000000000000,  // BLANK
      64'h182442427E424200,  // A
      64'h3C42404040423C00,  // C
      64'h7E40407C40407E00,  // E
      64'h3C42404E42423C00,  // G
      64'h4242427E42424200,  // H
      64'h3E08080808083E00,  // I
      64'h4040404040407E00,  // L
      64'h42665A4242424200,  // M
      64'h4262524A46424200,  // N
      64'h3C42424242423C00,  // O
      64'h7C42427C40404000,  // P
      64'h7C42427C48444200,  // R
      64'h3C42403C02423C00,  // S
      64'h7F08080808080800,  // T
      64'h4242424242423C00   // U
   };

   typedef enum logic [1:0] {
      MOVE_RIGHT,
      PAUSE_R,
      MOVE_LEFT,
      PAUSE_L
   } anim_state_t;

endpackage

// File: rtl/logo_glyph_rom.sv
// Combinational glyph row lookup: returns the 8-pixel row byte of a glyph.
module logo_glyph_rom
   import logo_pkg::*;
(
   input  logic [3:0] code,
   input  logic [2:0] row,
   output logic [7:0] bits
);

   logic [63:0] glyph;

   assign glyph = GLYPH_ROM[code];
   // ~row maps row 0 onto the most significant byte of the glyph word
   assign bits  = glyph[{~row, 3'b000} +: 8];

endmodule

// File: rtl/logo_scroll_painter.sv
// Paints a string of scaled bitmap glyphs at a horizontal offset that
// bounces between 0 and DELT_MAX, pausing at each end. hit/hit_index
// follow the x/y presented two clocks earlier.
// Optional macro LOGO_BLINK_EN: adds a 6-bit frame counter whose bit 5
// gates hit (32 frames visible, 32 frames dark).
module logo_scroll_painter
   import logo_pkg::*;
#(
   parameter int NUM_GLYPHS   = 4,
   parameter int SCALE_LOG2   = 2,
   parameter int GAP          = 4,
   parameter int X_BASE       = 500,
   parameter int Y_BASE       = 550,
   parameter int DELT_MAX     = 100,
   parameter int STEP         = 2,
   parameter int PAUSE_FRAMES = 30,
   localparam int IDX_W       = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    frame_start,
   input  logic [10:0]             x,
   input  logic [10:0]             y,
   input  logic [4*NUM_GLYPHS-1:0] text_codes,
   output logic                    hit,
   output logic [IDX_W-1:0]        hit_index,
   output logic [10:0]             delt
);

   localparam int CELL   = 8 << SCALE_LOG2;
   localparam int PITCH  = CELL + GAP;
   localparam int PCNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

   localparam logic signed [12:0] X_BASE_S  = 13'(X_BASE);
   localparam logic signed [12:0] Y_BASE_S  = 13'(Y_BASE);
   localparam logic signed [12:0] CELL_S    = 13'(CELL);
   localparam logic        [10:0] DMAX11    = 11'(DELT_MAX);
   localparam logic        [11:0] DMAX12    = 12'(DELT_MAX);
   localparam logic        [10:0] STEP11    = 11'(STEP);
   localparam logic        [11:0] STEP12    = 12'(STEP);
   localparam logic  [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PAUSE_FRAMES - 1);

   // ---------------- animation state ----------------
   anim_state_t       state, state_n;
   logic [10:0]       delt_r, delt_n;
   logic [PCNT_W-1:0] pcnt, pcnt_n;
   logic              adv;
   logic [11:0]       up_sum;

   assign adv    = frame_start & enable;
   assign up_sum = {1'b0, delt_r} + STEP12;
   assign delt   = delt_r;

   // Animation registers: offset, travel state and pause counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= MOVE_RIGHT;
         delt_r <= '0;
         pcnt   <= '0;
      end else begin
         state  <= state_n;
         delt_r <= delt_n;
         pcnt   <= pcnt_n;
      end
   end

   // Next-state: step the offset with saturation, then hold at each end.
   always_comb begin
      state_n = state;
      delt_n  = delt_r;
      pcnt_n  = pcnt;
      if (adv) begin
         case (state)
            MOVE_RIGHT: begin
               if (up_sum >= DMAX12) begin
                  delt_n  = DMAX11;
                  pcnt_n  = '0;
                  state_n = (PAUSE_FRAMES == 0) ? MOVE_LEFT : PAUSE_R;
               end else begin
                  delt_n = up_sum[10:0];
               end
            end
            PAUSE_R: begin
               if (pcnt >= PCNT_LAST) begin
                  pcnt_n  = '0;
                  state_n = MOVE_LEFT;
               end else begin
                  pcnt_n = pcnt + 1'b1;
               end
            end
            MOVE_LEFT: begin
               if ({1'b0, delt_r} <= STEP12) begin
                  delt_n  = '0;
                  pcnt_n  = '0;
                  state_n = (PAUSE_FRAMES == 0) ? MOVE_RIGHT : PAUSE_L;
               end else begin
                  delt_n = delt_r - STEP11;
               end
            end
            PAUSE_L: begin
               if (pcnt >= PCNT_LAST) begin
                  pcnt_n  = '0;
                  state_n = MOVE_RIGHT;
               end else begin
                  pcnt_n = pcnt + 1'b1;
               end
            end
            default: state_n = MOVE_RIGHT;
         endcase
      end
   end

   // ---------------- optional blink gate ----------------
   logic blink_on;
`ifdef LOGO_BLINK_EN
   logic [5:0] blink_cnt;

   // Frame counter; its MSB selects the visible half of each 64-frame cycle.
   always_ff @(posedge clk) begin
      if (rst)
         blink_cnt <= '0;
      else if (adv)
         blink_cnt <= blink_cnt + 6'd1;
   end

   assign blink_on = blink_cnt[5];
`else
   assign blink_on = 1'b1;
`endif

   // ---------------- stage 0: slot decode ----------------
   logic signed [12:0] dx, dy, off;
   logic               sel_vld, row_vld;
   logic [IDX_W-1:0]   sel_idx;
   logic [2:0]         sel_col;
   logic [3:0]         sel_code;

   assign dx      = $signed({2'b00, x}) - X_BASE_S - $signed({2'b00, delt_r});
   assign dy      = $signed({2'b00, y}) - Y_BASE_S;
   assign row_vld = (dy >= 13'sd0) && (dy < CELL_S);

   // Find the glyph cell (if any) containing dx; gaps and negatives select none.
   always_comb begin
      sel_vld  = 1'b0;
      sel_idx  = '0;
      sel_col  = '0;
      sel_code = '0;
      off      = '0;
      for (int i = 0; i < NUM_GLYPHS; i++) begin
         off = dx - 13'(i * PITCH);
         if (!sel_vld && (off >= 13'sd0) && (off < CELL_S)) begin
            sel_vld  = 1'b1;
            sel_idx  = IDX_W'(i);
            sel_col  = off[SCALE_LOG2 +: 3];
            sel_code = text_codes[4*i +: 4];
         end
      end
   end

   // ---------------- stage 1 register ----------------
   logic             vld_p1, en_p1;
   logic [IDX_W-1:0] idx_p1;
   logic [2:0]       col_p1, row_p1;
   logic [3:0]       code_p1;

   // Capture the decoded slot, glyph coordinates, code and enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         en_p1   <= 1'b0;
         idx_p1  <= '0;
         col_p1  <= '0;
         row_p1  <= '0;
         code_p1 <= '0;
      end else begin
         vld_p1  <= sel_vld & row_vld;
         en_p1   <= enable;
         idx_p1  <= sel_idx;
         col_p1  <= sel_col;
         row_p1  <= dy[SCALE_LOG2 +: 3];
         code_p1 <= sel_code;
      end
   end

   logic [7:0] rom_bits;

   logo_glyph_rom u_rom (
      .code (code_p1),
      .row  (row_p1),
      .bits (rom_bits)
   );

   // ---------------- stage 2 register ----------------
   logic             hit_p1;
   logic             hit_p2;
   logic [IDX_W-1:0] idx_p2;

   assign hit_p1 = vld_p1 & rom_bits[~col_p1] & en_p1 & blink_on;

   // Register the lit-pixel flag; the index is zeroed when nothing is lit.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_p2 <= 1'b0;
         idx_p2 <= '0;
      end else begin
         hit_p2 <= hit_p1;
         idx_p2 <= hit_p1 ? idx_p1 : '0;
      end
   end

   assign hit       = hit_p2;
   assign hit_index = idx_p2;

endmodule

// File: tb/tb_logo_scroll_painter.sv
// Scoreboard bench for logo_scroll_painter: pixel stimulus pushes the
// expected hit/index two cycles ahead, a negedge monitor pops and compares.
module tb_logo_scroll_painter;

   logic        clk = 1'b0;
   logic        rst, enable, frame_start;
   logic [10:0] x, y;
   logic [15:0] text_codes;
   logic        hit;
   logic [1:0]  hit_index;
   logic [10:0] delt;

   always #5 clk = ~clk;

   logo_scroll_painter #(
      .NUM_GLYPHS(4), .SCALE_LOG2(2), .GAP(4), .X_BASE(500), .Y_BASE(550),
      .DELT_MAX(100), .STEP(2), .PAUSE_FRAMES(30)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .frame_start (frame_start),
      .x           (x),
      .y           (y),
      .text_codes  (text_codes),
      .hit         (hit),
      .hit_index   (hit_index),
      .delt        (delt)
   );

   typedef struct {
      int due;
      bit h;
      int idx;
      int px;
      int py;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   exp_delt = 0;
   int   nframes = 0;
   int   blink_frames = 0;
   int   scan_y[4] = '{549, 550, 558, 582};

   always @(posedge clk) cyc <= cyc + 1;

   // Hand-entered row bytes for the two glyphs the bench uses (A, M).
   function automatic logic [7:0] font(input logic [3:0] code, input int row);
      logic [7:0] b;
      b = 8'h00;
      if (code == 4'd1) begin
         case (row)
            0: b = 8'h18; 1: b = 8'h24; 2: b = 8'h42; 3: b = 8'h42;
            4: b = 8'h7E; 5: b = 8'h42; 6: b = 8'h42; default: b = 8'h00;
         endcase
      end else if (code == 4'd8) begin
         case (row)
            0: b = 8'h42; 1: b = 8'h66; 2: b = 8'h5A; 3: b = 8'h42;
            4: b = 8'h42; 5: b = 8'h42; 6: b = 8'h42; default: b = 8'h00;
         endcase
      end
      return b;
   endfunction

   function automatic void model(input int px, input int py, input logic [15:0] codes,
                                 input int d, input bit en, output bit h, output int idx);
      int dx, dy, slot, off;
      logic [3:0] code;
      logic [7:0] b;
      h   = 1'b0;
      idx = 0;
      dx  = px - 500 - d;
      dy  = py - 550;
      if (!en || dx < 0 || dy < 0 || dy >= 32) return;
      slot = dx / 36;
      off  = dx - slot * 36;
      if (slot >= 4 || off >= 32) return;
      code = codes[4*slot +: 4];
      b    = font(code, dy / 4);
      h    = b[7 - off / 4];
`ifdef LOGO_BLINK_EN
      if (blink_frames[5] == 1'b0) h = 1'b0;
`endif
      idx = h ? slot : 0;
   endfunction

   function automatic int delt_model(input int n);
      if (n <= 50)  return 2 * n;
      if (n <= 80)  return 100;
      if (n <= 130) return 100 - 2 * (n - 80);
      return 0;
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (frame %0d)", nm, act, exp_v, nframes);
      end
   endtask

   task automatic px(input int xx, input int yy);
      bit h;
      int idx;
      @(posedge clk);
      #1;
      x = 11'(xx);
      y = 11'(yy);
      model(xx, yy, text_codes, exp_delt, enable, h, idx);
      q.push_back('{cyc + 2, h, idx, xx, yy});
   endtask

   task automatic frame();
      @(posedge clk);
      #1 frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
      if (enable) begin
         nframes++;
         blink_frames++;
         exp_delt = delt_model(nframes);
      end
      chk("delt", int'(delt), exp_delt);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected outputs still pending, required 0", q.size());
         q.delete();
      end
   endtask

   // Monitor: compare each due expectation against the DUT outputs.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         mon_e = q.pop_front();
         checks++;
         if (hit !== mon_e.h || int'(hit_index) != mon_e.idx) begin
            errors++;
            $display("FAIL pixel x=%0d y=%0d: hit=%0b idx=%0d required hit=%0b idx=%0d",
                     mon_e.px, mon_e.py, hit, hit_index, mon_e.h, mon_e.idx);
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; enable = 1'b1; frame_start = 1'b0;
      x = '0; y = '0;
      text_codes = 16'h0081;           // slot0 = A, slot1 = M, slots 2/3 blank
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_delt", int'(delt), 0);
      chk("reset_hit", int'(hit), 0);
      chk("reset_idx", int'(hit_index), 0);

      // Row scans across all slots, the gap and out-of-band rows at delt=0.
      for (int k = 0; k < 4; k++)
         for (int xx = 498; xx <= 640; xx++)
            px(xx, scan_y[k]);
      drain();

      // A lit pixel with enable low must stay dark.
      @(posedge clk);
      #1 enable = 1'b0;
      px(512, 550);
      drain();
      enable = 1'b1;

      for (int i = 0; i < 20; i++) frame();       // delt -> 40

      enable = 1'b0;
      for (int i = 0; i < 10; i++) frame();       // frozen at 40
      px(552, 550);
      drain();
      enable = 1'b1;
      frame();                                    // delt -> 42
      px(554, 550);                               // slot 0 lit
      px(582, 550);                               // slot 1 (M) lit
      drain();

      while (nframes < 142) begin
         frame();
         if (nframes == 80) begin
            px(612, 550);
            drain();
         end
      end

      // Now in PAUSE_L with counter 12; reset must restart the travel.
      px(512, 550);
      px(512, 550);
      drain();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      nframes = 0;
      blink_frames = 0;
      exp_delt = 0;
      chk("rst_pause_delt", int'(delt), 0);
      chk("rst_pause_hit", int'(hit), 0);
      chk("rst_pause_idx", int'(hit_index), 0);
      frame();                                    // delt -> 2
      px(2047, 550);                              // far right edge, no wrap
      drain();

      while (nframes < 33) frame();               // delt -> 66
      px(578, 550);
      px(578, 558);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
